// File: rtl/rst_ctrl_pkg.sv
// Shared types and defaults for the clk_sys reset sequencer.
package rst_ctrl_pkg;

    typedef enum logic [2:0] {
        StWait,
        StHold,
        StPeriph,
        StRun,
        StSw
    } rst_state_e;

    typedef enum logic [1:0] {
        RstCausePor,
        RstCausePll,
        RstCauseBtn,
        RstCauseSw
    } rst_cause_e;

    localparam int unsigned DefSyncStages     = 2;
    localparam int unsigned DefDebounceCycles = 50000;
    localparam int unsigned DefHoldCycles     = 16;
    localparam int unsigned DefStageGap       = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_btn_debounce.sv
// Board reset button synchroniser and debouncer; btn_db only follows a change that
// stays stable for DebounceCycles consecutive clk_sys cycles.
module rst_btn_debounce
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned SyncStages     = DefSyncStages,
    parameter int unsigned DebounceCycles = DefDebounceCycles
) (
    input  logic clk_sys,
    input  logic rst_sys,
    input  logic btn_rst_ni,
    output logic btn_db
);

    localparam int unsigned CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  btn_s;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  db_q, db_d;

    assign btn_s = sync_q[SyncStages-1];

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (btn_s != db_q) begin
            if (cnt_q == CntLast) begin
                db_d = btn_s;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Button resets to "released" so a POR never looks like a press.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            sync_q <= '1;
            cnt_q  <= '0;
            db_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], btn_rst_ni};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign btn_db = db_q;

endmodule

// File: rtl/rst_ctrl_sys.sv
// Reset sequencer: staged peripheral/core release after PLL lock and button are good,
// debug ndmreset handling for the core, and latched cause of the last reset.
module rst_ctrl_sys
    import rst_ctrl_pkg::*;
#(
    parameter int unsigned SyncStages     = DefSyncStages,
    parameter int unsigned DebounceCycles = DefDebounceCycles,
    parameter int unsigned HoldCycles     = DefHoldCycles,
    parameter int unsigned StageGap       = DefStageGap
) (
    input  logic       clk_sys,
    input  logic       rst_sys,
    input  logic       pll_locked_i,
    input  logic       btn_rst_ni,
    input  logic       ndmreset_req_i,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic [1:0] rst_cause_o
);

    localparam int unsigned CntW = $clog2(max_u(HoldCycles, StageGap) + 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(StageGap - 1);

    logic [SyncStages-1:0] lock_sync_q;
    logic                  locked_s;
    logic                  btn_db;
    logic                  press;

    rst_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            periph_q, periph_d;
    logic            core_q, core_d;
    rst_cause_e      cause_q, cause_d;

    rst_btn_debounce #(
        .SyncStages     (SyncStages),
        .DebounceCycles (DebounceCycles)
    ) u_btn_debounce (
        .clk_sys    (clk_sys),
        .rst_sys    (rst_sys),
        .btn_rst_ni (btn_rst_ni),
        .btn_db     (btn_db)
    );

    assign locked_s = lock_sync_q[SyncStages-1];
    assign press    = ~btn_db;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        periph_d = periph_q;
        core_d   = core_q;
        cause_d  = cause_q;

        case (state_q)
            StWait: begin
                periph_d = 1'b0;
                core_d   = 1'b0;
                if (locked_s && !press) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == HoldLast) begin
                    state_d  = StPeriph;
                    periph_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPeriph: begin
                if (cnt_q == GapLast) begin
                    state_d = StRun;
                    core_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (ndmreset_req_i) begin
                    state_d = StSw;
                    core_d  = 1'b0;
                    cause_d = RstCauseSw;
                end
            end
            StSw: begin
                // Hold time restarts for as long as the debugger keeps requesting.
                if (ndmreset_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    core_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d  = StWait;
                periph_d = 1'b0;
                core_d   = 1'b0;
            end
        endcase

        // Lock loss outranks a button press; both override any sequencing step.
        if (state_q != StWait) begin
            if (!locked_s) begin
                state_d  = StWait;
                cnt_d    = '0;
                periph_d = 1'b0;
                core_d   = 1'b0;
                cause_d  = RstCausePll;
            end else if (press) begin
                state_d  = StWait;
                cnt_d    = '0;
                periph_d = 1'b0;
                core_d   = 1'b0;
                cause_d  = RstCauseBtn;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            lock_sync_q <= '0;
            state_q     <= StWait;
            cnt_q       <= '0;
            periph_q    <= 1'b0;
            core_q      <= 1'b0;
            cause_q     <= RstCausePor;
        end else begin
            lock_sync_q <= {lock_sync_q[SyncStages-2:0], pll_locked_i};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            periph_q    <= periph_d;
            core_q      <= core_d;
            cause_q     <= cause_d;
        end
    end

    assign rst_periph_no = periph_q;
    assign rst_core_no   = core_q;
    assign rst_cause_o   = cause_q;

endmodule

// File: tb/tb_rst_ctrl_sys.sv
// Directed bench for rst_ctrl_sys with a short debounce window; edge counts are hand-derived.
module tb_rst_ctrl_sys;

    logic       clk_sys = 1'b0;
    logic       rst_sys;
    logic       pll_locked_i;
    logic       btn_rst_ni;
    logic       ndmreset_req_i;
    logic       rst_periph_no;
    logic       rst_core_no;
    logic [1:0] rst_cause_o;

    int total = 0;
    int bad   = 0;

    rst_ctrl_sys #(
        .SyncStages     (2),
        .DebounceCycles (8),
        .HoldCycles     (16),
        .StageGap       (4)
    ) dut (
        .clk_sys        (clk_sys),
        .rst_sys        (rst_sys),
        .pll_locked_i   (pll_locked_i),
        .btn_rst_ni     (btn_rst_ni),
        .ndmreset_req_i (ndmreset_req_i),
        .rst_periph_no  (rst_periph_no),
        .rst_core_no    (rst_core_no),
        .rst_cause_o    (rst_cause_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    initial begin
        rst_sys        = 1'b1;
        pll_locked_i   = 1'b1;
        btn_rst_ni     = 1'b1;
        ndmreset_req_i = 1'b0;

        // 1: POR sequence
        tick(3);
        check("rst_periph", rst_periph_no, 0);
        check("rst_core", rst_core_no, 0);
        check("rst_cause", rst_cause_o, 0);
        rst_sys = 1'b0;
        tick(18);
        check("por_periph_e18", rst_periph_no, 0);
        tick(1);
        check("por_periph_e19", rst_periph_no, 1);
        check("por_core_e19", rst_core_no, 0);
        tick(3);
        check("por_core_e22", rst_core_no, 0);
        tick(1);
        check("por_core_e23", rst_core_no, 1);
        check("por_cause", rst_cause_o, 0);

        // 2: one-cycle lock loss in RUN
        pll_locked_i = 1'b0;
        tick(1);
        pll_locked_i = 1'b1;
        tick(1);
        check("pll_periph_e2", rst_periph_no, 1);
        tick(1);
        check("pll_periph_e3", rst_periph_no, 0);
        check("pll_core_e3", rst_core_no, 0);
        check("pll_cause", rst_cause_o, 1);
        tick(16);
        check("pll_reseq_periph_e19", rst_periph_no, 0);
        tick(1);
        check("pll_reseq_periph_e20", rst_periph_no, 1);
        tick(4);
        check("pll_reseq_core_e24", rst_core_no, 1);

        // 3: bounce is filtered, a steady press is not
        for (int i = 0; i < 10; i++) begin
            btn_rst_ni = ~btn_rst_ni;
            tick(3);
        end
        tick(12);
        check("bounce_periph", rst_periph_no, 1);
        check("bounce_core", rst_core_no, 1);
        check("bounce_cause", rst_cause_o, 1);
        btn_rst_ni = 1'b0;
        tick(10);
        check("press_core_e10", rst_core_no, 1);
        tick(1);
        check("press_periph_e11", rst_periph_no, 0);
        check("press_core_e11", rst_core_no, 0);
        check("press_cause", rst_cause_o, 2);
        btn_rst_ni = 1'b1;
        tick(26);
        check("release_periph_e26", rst_periph_no, 0);
        tick(1);
        check("release_periph_e27", rst_periph_no, 1);
        tick(3);
        check("release_core_e30", rst_core_no, 0);
        tick(1);
        check("release_core_e31", rst_core_no, 1);
        check("release_cause", rst_cause_o, 2);

        // 4: ndmreset pulse resets the core only
        ndmreset_req_i = 1'b1;
        tick(1);
        ndmreset_req_i = 1'b0;
        check("ndm_core", rst_core_no, 0);
        check("ndm_periph", rst_periph_no, 1);
        check("ndm_cause", rst_cause_o, 3);
        tick(15);
        check("ndm_core_e15", rst_core_no, 0);
        tick(1);
        check("ndm_core_e16", rst_core_no, 1);

        // 5: lock loss and press seen on the same FSM edge while in SW
        ndmreset_req_i = 1'b1;
        tick(1);
        check("prio_sw_core", rst_core_no, 0);
        btn_rst_ni = 1'b0;
        tick(8);
        pll_locked_i = 1'b0;
        tick(2);
        check("prio_still_sw", rst_periph_no, 1);
        tick(1);
        check("prio_periph", rst_periph_no, 0);
        check("prio_core", rst_core_no, 0);
        check("prio_cause", rst_cause_o, 1);

        // 6: async rst_sys mid-HOLD
        ndmreset_req_i = 1'b0;
        pll_locked_i   = 1'b1;
        btn_rst_ni     = 1'b1;
        tick(20);
        #2;
        rst_sys = 1'b1;
        #1;
        check("async_periph", rst_periph_no, 0);
        check("async_core", rst_core_no, 0);
        check("async_cause", rst_cause_o, 0);
        tick(2);
        rst_sys = 1'b0;
        tick(18);
        check("async_reseq_periph_e18", rst_periph_no, 0);
        tick(1);
        check("async_reseq_periph_e19", rst_periph_no, 1);
        tick(4);
        check("async_reseq_core_e23", rst_core_no, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
